proc_1_cpu_ocimem_ctrl: RTL

Downstream consumer of the debug-slave wrapper's jdo bus and its ocimem take-action strobes. Owns the 256x32 on-chip debug monitor RAM. Arbitrates that RAM between JTAG host commands and the CPU's Avalon debug_mem_slave port. Returns JTAG read data on MonDReg, which feeds back into the wrapper's TCK-side shift register.

---
 rtl/proc_1_cpu_ocimem_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/proc_1_cpu_ocimem_ctrl.sv
// rtl/proc_1_cpu_ocimem_ctrl.sv - OCI debug monitor RAM shared between JTAG commands and the CPU debug slave
module proc_1_cpu_ocimem_ctrl #(
  parameter int ADDR_W      = 8,
  parameter int MONAREG_RST = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic [3:0]        byteenable,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              debugaccess,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic [ADDR_W-1:0] MonAReg,
  output logic              jtag_overrun
);

  typedef enum logic [1:0] {IDLE, AV_RD, JT_RD, JT_EXEC} state_t;
  typedef enum logic [1:0] {CMD_A, CMD_NA, CMD_B} cmd_t;

  state_t            state, state_d;
  cmd_t              cmd_q, strobe_cmd;
  logic [37:0]       jdo_q;
  logic              pend, strobe, accept;
  logic [31:0]       readdata_q, readdata_d, mond_d, ram_q, ram_wdata;
  logic [ADDR_W-1:0] mona_d, mona_inc, ram_addr, jt_addr;
  logic [3:0]        ram_be;
  logic              ram_rd, ram_wr, av_write_accept;
  logic [31:0]       mem [2**ADDR_W];
  logic              unused_jdo;

  assign strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign accept     = strobe & ~pend;
  assign jt_addr    = jdo_q[ADDR_W+25:26];
  assign mona_inc   = MonAReg + ADDR_W'(1);
  assign unused_jdo = ^{jdo_q[37:35], jdo_q[2:0]};

  always_comb begin
    strobe_cmd = CMD_B;
    if (take_action_ocimem_a)         strobe_cmd = CMD_A;
    else if (take_no_action_ocimem_a) strobe_cmd = CMD_NA;
  end

  // A strobe seen in IDLE with nothing pending executes directly; otherwise it waits in pend.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pend         <= 1'b0;
      cmd_q        <= CMD_A;
      jdo_q        <= '0;
      MonAReg      <= ADDR_W'(MONAREG_RST);
      MonDReg      <= '0;
      readdata_q   <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      state      <= state_d;
      MonAReg    <= mona_d;
      MonDReg    <= mond_d;
      readdata_q <= readdata_d;
      if (accept) begin
        cmd_q <= strobe_cmd;
        jdo_q <= jdo;
      end
      if (strobe && pend) jtag_overrun <= 1'b1;
      if (accept && state != IDLE) pend <= 1'b1;
      else if (state == IDLE)      pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  always_comb begin
    state_d         = state;
    mona_d          = MonAReg;
    mond_d          = MonDReg;
    readdata_d      = readdata_q;
    ram_rd          = 1'b0;
    ram_wr          = 1'b0;
    ram_addr        = address;
    ram_wdata       = writedata;
    ram_be          = byteenable;
    av_write_accept = 1'b0;
    case (state)
      IDLE: begin
        if (pend || strobe) begin
          state_d = JT_EXEC;
        end else if (read) begin
          ram_rd  = 1'b1;
          state_d = AV_RD;
        end else if (write) begin
          av_write_accept = 1'b1;
          ram_wr          = debugaccess;
        end
      end
      JT_EXEC: begin
        state_d = IDLE;
        case (cmd_q)
          CMD_A: begin
            mona_d = jt_addr;
            if (jdo_q[34]) begin
              ram_rd   = 1'b1;
              ram_addr = jt_addr;
              state_d  = JT_RD;
            end
          end
          CMD_NA: begin
            mona_d   = mona_inc;
            ram_rd   = 1'b1;
            ram_addr = mona_inc;
            state_d  = JT_RD;
          end
          CMD_B: begin
            ram_wr    = 1'b1;
            ram_addr  = MonAReg;
            ram_wdata = jdo_q[34:3];
            ram_be    = 4'hF;
            mond_d    = jdo_q[34:3];
            mona_d    = mona_inc;
          end
          default: ;
        endcase
      end
      JT_RD: begin
        mond_d  = ram_q;
        state_d = IDLE;
      end
      AV_RD: begin
        readdata_d = ram_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is presented straight from the RAM during the AV_RD cycle, then held.
  assign readdata    = (state == AV_RD) ? ram_q : readdata_q;
  assign waitrequest = (read | write) & ~(av_write_accept | (state == AV_RD));

endmodule
